// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one 32-bit schedule word per clock into a
// 15x128 round-key store, with a per-round valid flag so the cipher core can
// start on round 0 before expansion finishes.
// Optional build macro: KEY_ZEROIZE_EN adds a zeroize input that wipes the store.

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;
  assign inv  = ginv(din);
  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expand #(
  parameter int MAX_RK = 15,
  parameter int WORD_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  output logic [3:0]   Nr,
  input  logic [3:0]   rk_addr,
  output logic [128:0] rk_out,
  output logic         key_done
);
  localparam int WORDS = 4 * MAX_RK;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   w [WORDS];
  logic [MAX_RK-1:0]   vld;
  logic [3:0]          nr_q, nk_q, nk_new;
  logic [5:0]          i_q, prev_idx, base_idx, last_idx;
  logic [2:0]          j_q;
  logic [7:0]          rcon_q;
  logic [WORD_W-1:0]   prev, sub_in, sub_out, temp, new_word;
  logic                zap, accept, is_last, j_wrap;
  logic [3:0]          sel;

`ifdef KEY_ZEROIZE_EN
  assign zap = zeroize;
`else
  assign zap = 1'b0;
`endif

  assign nk_new   = (key_len == 2'd1) ? 4'd6 : (key_len == 2'd2) ? 4'd8 : 4'd4;
  assign prev_idx = i_q - 6'd1;
  assign base_idx = i_q - {2'b00, nk_q};
  assign last_idx = {nr_q, 2'b11};
  assign is_last  = (i_q == last_idx);
  assign j_wrap   = ({1'b0, j_q} == (nk_q - 4'd1));
  assign prev     = w[prev_idx];
  assign sub_in   = (j_q == 3'd0) ? {prev[7:0], prev[31:8]} : prev;

  // SubWord: one S-box per byte lane
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.din(sub_in[8*g +: 8]), .dout(sub_out[8*g +: 8]));
  end

  // Schedule word mix: RotWord/SubWord/Rcon at phase 0, extra SubWord at phase 4 for 256-bit keys
  always_comb begin
    temp = prev;
    if (j_q == 3'd0)                      temp = sub_out ^ {24'h0, rcon_q};
    else if (nk_q == 4'd8 && j_q == 3'd4) temp = sub_out;
  end

  assign new_word = w[base_idx] ^ temp;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state, handshake and acceptance strobe
  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    key_done  = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_d = EXPAND;
      end
      EXPAND: if (is_last) state_d = DONE;
      DONE: begin
        key_ready = 1'b1;
        key_done  = 1'b1;
        if (key_valid) state_d = EXPAND;
      end
      default: state_d = IDLE;
    endcase
    if (zap) state_d = IDLE;
    accept = key_valid && key_ready && !zap;
  end

  // Store, valid flags and expansion counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WORDS; k++) w[k] <= '0;
      vld    <= '0;
      nr_q   <= 4'd0;
      nk_q   <= 4'd4;
      i_q    <= 6'd0;
      j_q    <= 3'd0;
      rcon_q <= 8'h01;
    end else if (zap) begin
      for (int k = 0; k < WORDS; k++) w[k] <= '0;
      vld  <= '0;
      nr_q <= 4'd0;
    end else if (accept) begin
      for (int k = 0; k < 8; k++)
        if (k < int'(nk_new)) w[k] <= key_in[32*k +: 32];
      vld    <= '0;
      vld[0] <= 1'b1;
      if (nk_new == 4'd8) vld[1] <= 1'b1;
      nk_q   <= nk_new;
      nr_q   <= nk_new + 4'd6;
      i_q    <= {2'b00, nk_new};
      j_q    <= 3'd0;
      rcon_q <= 8'h01;
    end else if (state_q == EXPAND) begin
      w[i_q] <= new_word;
      if (i_q[1:0] == 2'b11) vld[i_q[5:2]] <= 1'b1;
      i_q <= i_q + 6'd1;
      if (j_wrap) begin
        j_q    <= 3'd0;
        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end else begin
        j_q <= j_q + 3'd1;
      end
    end
  end

  assign Nr  = nr_q;
  assign sel = (rk_addr > nr_q) ? 4'd0 : rk_addr;
  assign rk_out = (rk_addr > nr_q) ? '0 :
                  {vld[sel], w[{sel, 2'd3}], w[{sel, 2'd2}], w[{sel, 2'd1}], w[{sel, 2'd0}]};
endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized bench for aes_key_expand against a FIPS-197 style reference schedule.
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid, key_ready, key_done;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic [3:0]   Nr, rk_addr;
  logic [128:0] rk_out;
`ifdef KEY_ZEROIZE_EN
  logic         zeroize;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]  sb [256];
  logic [7:0]  rcv [16];
  logic [31:0] mw [60];
  int          m_nr, m_nk;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n),
`ifdef KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .key_len(key_len),
    .Nr(Nr), .rk_addr(rk_addr), .rk_out(rk_out), .key_done(key_done)
  );

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // S-box table from the log/antilog generator walk, Rcon by repeated doubling
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    rcv[1] = 8'h01;
    for (int k = 2; k < 16; k++)
      rcv[k] = {rcv[k-1][6:0], 1'b0} ^ (rcv[k-1][7] ? 8'h1b : 8'h00);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sb[t[8*b +: 8]];
    return r;
  endfunction

  task automatic model(input logic [255:0] key, input logic [1:0] len);
    logic [31:0] t;
    m_nk = (len == 2'd1) ? 6 : (len == 2'd2) ? 8 : 4;
    m_nr = m_nk + 6;
    for (int i = 0; i < m_nk; i++) mw[i] = key[32*i +: 32];
    for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % m_nk == 0)                t = subw({t[7:0], t[31:8]}) ^ {24'h0, rcv[i / m_nk]};
      else if (m_nk > 6 && i % m_nk == 4) t = subw(t);
      mw[i] = mw[i-m_nk] ^ t;
    end
  endtask

  function automatic logic [128:0] exp_rk(input int a);
    if (a > m_nr) return '0;
    return {1'b1, mw[4*a+3], mw[4*a+2], mw[4*a+1], mw[4*a]};
  endfunction

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rk_addr = 4'(a);
      #1;
      chk($sformatf("%s_rk%0d", tag, a), rk_out, exp_rk(a));
    end
    chk({tag, "_nr"}, {125'd0, Nr}, 129'(m_nr));
  endtask

  // Load a key, track progressive valid and key_done each cycle, optionally poke
  // key_valid mid-expansion or pulse reset; full store sweep at the end.
  task automatic run_key(input logic [255:0] key, input logic [1:0] len,
                         input int probe, input int poke_at, input int rst_at);
    int lat, pr, vis;
    logic ev;
    model(key, len);
    lat = 4 * (m_nr + 1) - m_nk;
    pr  = (probe < 0) ? int'($urandom_range(0, 15)) : probe;
    vis = 4 * pr + 4 - m_nk;
    if (vis < 0) vis = 0;
    @(negedge clk);
    key_in = key; key_len = len; key_valid = 1'b1;
    for (int n = 0; n <= lat; n++) begin
      @(negedge clk);
      key_valid = (n == poke_at);
      if (n == poke_at) begin key_in = ~key; key_len = 2'd2; end
      rk_addr = 4'(pr);
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {128'd0, key_ready}, 129'd1);
        chk("rst_done",  {128'd0, key_done}, 129'd0);
        chk("rst_nr",    {125'd0, Nr}, 129'd0);
        chk("rst_rk",    rk_out, 129'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      #1;
      ev = (pr <= m_nr) && (n >= vis);
      chk($sformatf("vld_r%0d_n%0d", pr, n), {128'd0, rk_out[128]}, {128'd0, ev});
      if (ev || pr > m_nr) chk($sformatf("rk_r%0d_n%0d", pr, n), rk_out, exp_rk(pr));
      chk($sformatf("done_n%0d", n),  {128'd0, key_done},  {128'd0, (n == lat)});
      chk($sformatf("ready_n%0d", n), {128'd0, key_ready}, {128'd0, (n == lat)});
    end
    key_valid = 1'b0;
    sweep($sformatf("len%0d", len));
  endtask

  initial begin
    build_tables();
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; key_len = 2'd0; rk_addr = 4'd0;
`ifdef KEY_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    #1;
    chk("reset_ready", {128'd0, key_ready}, 129'd1);
    chk("reset_done",  {128'd0, key_done}, 129'd0);
    chk("reset_nr",    {125'd0, Nr}, 129'd0);
    chk("reset_rk0",   rk_out, 129'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rk_addr = 4'd5;
    #1;
    chk("idle_rk5", rk_out, 129'd0);

    // FIPS-197 AES-128 vector, round 1 watched for progressive valid
    run_key({128'd0, 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b}, 2'd0, 1, -1, -1);
    @(negedge clk); rk_addr = 4'd1; #1;
    chk("fips128_rk1", rk_out, 129'h1_05766c2a_3939a323_b12c5488_17fefaa0);
    @(negedge clk); rk_addr = 4'd10; #1;
    chk("fips128_rk10", rk_out, 129'h1_a60c63b6_c80c3fe1_8925eec9_a8f914d0);

    // FIPS-197 AES-256 vector
    run_key(256'hf4df1409_a310982d_d708613b_072c351f_81777d85_f0ae732b_be71ca15_10eb3d60,
            2'd2, 1, -1, -1);
    @(negedge clk); rk_addr = 4'd14; #1;
    chk("fips256_rk14", rk_out, 129'h1_1e636c70_44f36d04_0b8d18e6_d19048fe);

    // out-of-range round stays zero; key_valid poked mid-expansion is ignored
    run_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            2'd0, 11, 10, -1);

    // reset in the middle of an expansion, then a normal load
    run_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            2'd0, 0, -1, 20);
    run_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            2'd1, -1, -1, -1);

    for (int t = 0; t < 6; t++)
      run_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              2'($urandom_range(0, 3)), -1, -1, -1);

`ifdef KEY_ZEROIZE_EN
    // zeroize in DONE beats a simultaneous key_valid
    @(negedge clk);
    zeroize = 1'b1; key_valid = 1'b1;
    @(negedge clk);
    zeroize = 1'b0; key_valid = 1'b0;
    #1;
    chk("zero_ready", {128'd0, key_ready}, 129'd1);
    chk("zero_done",  {128'd0, key_done}, 129'd0);
    m_nr = 0;
    for (int a = 0; a < 60; a++) mw[a] = '0;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rk_addr = 4'(a);
      #1;
      chk($sformatf("zero_rk%0d", a), rk_out, 129'd0);
    end
    chk("zero_nr", {125'd0, Nr}, 129'd0);
    chk("zero_idle_ready", {128'd0, key_ready}, 129'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES key schedule; sits directly upstream of the encrypt/decrypt core.
- Accepts a 128/192/256-bit cipher key and generates one 32-bit schedule word per cycle into a 15x128 round-key store.
- The core indexes the store with its 4-bit round address and gets {valid, round_key}, with valid in bit 128. Valid rises per round as the words for that round are written, so encryption starts before expansion finishes.

Parameters:
- MAX_RK, 15, number of round-key slots (round 0..14); fixed for AES-256.
- WORD_W, 32, schedule word width; fixed.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- key_valid  in  1  new cipher key offered
- key_ready  out  1  block can accept a key (IDLE or DONE state)
- key_in  in  256  cipher key; word k = key_in[32k+31:32k], byte 0 of each word in bits [7:0]; AES-128 uses words 0-3, AES-192 uses words 0-5
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3 treated as AES-128; sampled on acceptance
- Nr  out  4  round count of the current key: 10/12/14; 0 after reset
- rk_addr  in  4  round index from the core
- rk_out  out  129  bit 128 = valid for slot rk_addr; [127:0] = round key (byte 0 in [7:0]); combinational read
- key_done  out  1  full schedule complete; level

Behaviour:
- Reset: state IDLE, all valid flags 0, store 0, Nr=0, key_done=0, key_ready=1, rk_out=0.
- States and transitions:
  - IDLE: key_ready=1. key_valid goes to EXPAND.
  - EXPAND: key_ready=0; key_valid is ignored.
  - DONE: key_ready=1, key_done=1. key_valid goes to EXPAND (reload).
- Acceptance edge E0 (key_valid && key_ready):
  - write words 0..Nk-1 from key_in; Nk = 4/6/8.
  - latch Nr = 10/12/14; clear every valid flag, then set the flags for rounds fully covered by the written words (AES-128: round 0; AES-192: round 0; AES-256: rounds 0-1).
  - set word index i=Nk, phase j=0, rcon=8'h01; key_done=0.
- EXPAND, one word per edge:
  - temp = w[i-1].
  - j==0: temp = SubWord(RotWord(temp)) ^ {24'h0, rcon}. RotWord = {temp[7:0], temp[31:8]}.
  - Nk==8 && j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - then i++; j wraps at Nk-1; rcon = xtime(rcon) when j wraps. xtime = shift left 1, XOR 8'h1b on carry.
  - SubWord uses 4 forward aes_sbox instances; no divider, modulo handled by the phase counter j.
- Valid flag r sets on the same edge that writes word 4r+3. It is visible through rk_out the following cycle, from the register.
- Last word index = 4*(Nr+1)-1. Writing it sets state DONE and key_done=1 on that edge.
- Latency from E0 to the last word: AES-128 40 edges, AES-192 46, AES-256 52.
- rk_out:
  - rk_addr > Nr returns all zeros, valid=0.
  - In IDLE after reset, rk_out=0.
  - Store contents beyond Nr keep stale data, but valid stays 0.
- Reload in DONE clears all valid flags at E0. The consumer must not load while a block is in flight; no interlock is provided.
- Async reset mid-EXPAND returns to the reset values immediately; the partial schedule is discarded.
- key_valid held high across DONE causes one reload per entry to DONE: it is accepted on the first ready cycle, then ignored during EXPAND.

Optional Feature:
- KEY_ZEROIZE_EN defined:
  - adds input port zeroize (1 bit).
  - zeroize high at any edge clears the store to 0, clears all valid flags, sets Nr=0, key_done=0, state IDLE.
  - zeroize has priority over key_valid and over the expansion step on the same edge.
- KEY_ZEROIZE_EN undefined: port absent; the store is cleared only by reset and overwritten by reload.

Test Plan:
- AES-128, key_in[127:0]=128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b, key_len=0 -> after 40 edges key_done=1, Nr=10.
  - rk_addr=1 -> rk_out=129'h1_05766c2a_3939a323_b12c5488_17fefaa0.
  - rk_addr=10 -> 129'h1_a60c63b6_c80c3fe1_8925eec9_a8f914d0.
- AES-256, key_in=256'hf4df1409_a310982d_d708613b_072c351f_81777d85_f0ae732b_be71ca15_10eb3d60, key_len=2 -> after 52 edges Nr=14.
  - rk_addr=14 -> 129'h1_1e636c70_44f36d04_0b8d18e6_d19048fe.
- Progressive valid, AES-128:
  - rk_addr=1 valid=0 at E0+3, valid=1 at E0+4.
  - rk_addr=11 -> rk_out=0 throughout.
- key_valid pulsed mid-EXPAND (AES-128) -> ignored; key_ready=0; schedule and Nr unchanged; DONE at E0+40.
- Reset asserted at E0+20 -> all outputs return to reset values at once; a new load after release completes normally.
- KEY_ZEROIZE_EN defined, zeroize pulse in DONE together with key_valid -> rk_out=0 for all addresses, Nr=0, state IDLE, key not accepted.
